// File: rtl/gfx256_cuvz_arb.sv
// Round-robin two-port arbiter and sequencer for the shared colour/UV/Z interpolator.
// Issues the winner's operands, forwards the result strobe downstream and closes both handshakes.
module gfx256_cuvz_arb #(
    parameter int unsigned point_width = 16,
    parameter int unsigned timeout     = 255,
    localparam int unsigned cnt_width  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req0_i,
    input  logic [point_width-1:0] x0_i,
    input  logic [point_width-1:0] y0_i,
    input  logic [point_width-1:0] f00_i,
    input  logic [point_width-1:0] f01_i,
    output logic                   ack0_o,
    input  logic                   req1_i,
    input  logic [point_width-1:0] x1_i,
    input  logic [point_width-1:0] y1_i,
    input  logic [point_width-1:0] f10_i,
    input  logic [point_width-1:0] f11_i,
    output logic                   ack1_o,
    output logic                   cuvz_write_o,
    output logic [point_width-1:0] cuvz_x_o,
    output logic [point_width-1:0] cuvz_y_o,
    output logic [point_width-1:0] cuvz_f0_o,
    output logic [point_width-1:0] cuvz_f1_o,
    input  logic                   cuvz_write_i,
    output logic                   cuvz_ack_o,
    input  logic                   cuvz_ack_i,
    output logic                   pix_write_o,
    input  logic                   pix_ack_i,
    output logic                   owner_o,
    output logic                   busy_o,
    output logic                   err_o,
    input  logic                   clr_i,
    output logic [cnt_width-1:0]   cnt0_o,
    output logic [cnt_width-1:0]   cnt1_o
);

    localparam int unsigned wd_width = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CALC    = 3'd2,
        OUT     = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [wd_width-1:0]    wdog_q, wdog_d;
    logic                   owner_d, busy_d, err_d;
    logic                   ack0_d, ack1_d, cuvz_write_d, cuvz_ack_d, pix_write_d;
    logic [point_width-1:0] x_d, y_d, f0_d, f1_d;
    logic [cnt_width-1:0]   cnt0_d, cnt1_d;
    logic                   req0_m, req1_m, grant, abort, done;

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            owner_o      <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            ack0_o       <= 1'b0;
            ack1_o       <= 1'b0;
            cuvz_write_o <= 1'b0;
            cuvz_ack_o   <= 1'b0;
            pix_write_o  <= 1'b0;
            cuvz_x_o     <= '0;
            cuvz_y_o     <= '0;
            cuvz_f0_o    <= '0;
            cuvz_f1_o    <= '0;
            cnt0_o       <= '0;
            cnt1_o       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            owner_o      <= owner_d;
            busy_o       <= busy_d;
            err_o        <= err_d;
            ack0_o       <= ack0_d;
            ack1_o       <= ack1_d;
            cuvz_write_o <= cuvz_write_d;
            cuvz_ack_o   <= cuvz_ack_d;
            pix_write_o  <= pix_write_d;
            cuvz_x_o     <= x_d;
            cuvz_y_o     <= y_d;
            cuvz_f0_o    <= f0_d;
            cuvz_f1_o    <= f1_d;
            cnt0_o       <= cnt0_d;
            cnt1_o       <= cnt1_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        owner_d      = owner_o;
        err_d        = err_o & ~clr_i;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        cuvz_write_d = 1'b0;
        cuvz_ack_d   = 1'b0;
        pix_write_d  = pix_write_o;
        x_d          = cuvz_x_o;
        y_d          = cuvz_y_o;
        f0_d         = cuvz_f0_o;
        f1_d         = cuvz_f1_o;
        cnt0_d       = cnt0_o;
        cnt1_d       = cnt1_o;
        grant        = 1'b0;
        abort        = 1'b0;
        done         = 1'b0;
        // A requester still holding its line while its ack is out must not be re-granted
        req0_m       = req0_i & ~ack0_o;
        req1_m       = req1_i & ~ack1_o;

        case (state_q)
            IDLE: begin
                if (req0_m || req1_m) begin
                    grant        = (req0_m && req1_m) ? ~last_grant_q : req1_m;
                    owner_d      = grant;
                    last_grant_d = grant;
                    x_d          = grant ? x1_i  : x0_i;
                    y_d          = grant ? y1_i  : y0_i;
                    f0_d         = grant ? f10_i : f00_i;
                    f1_d         = grant ? f11_i : f01_i;
                    cuvz_write_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = wd_width'(timeout);
                state_d = CALC;
            end
            CALC: begin
                if (cuvz_write_i) begin
                    pix_write_d = 1'b1;
                    state_d     = OUT;
                end else if (wdog_q <= wd_width'(1)) begin
                    abort = 1'b1;
                end else begin
                    wdog_d = wdog_q - wd_width'(1);
                end
            end
            OUT: begin
                if (pix_write_o && pix_ack_i) begin
                    pix_write_d = 1'b0;
                    cuvz_ack_d  = 1'b1;
                    wdog_d      = wd_width'(timeout);
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                if (cuvz_ack_i) begin
                    done = 1'b1;
                end else if (wdog_q <= wd_width'(1)) begin
                    abort = 1'b1;
                end else begin
                    wdog_d = wdog_q - wd_width'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort || done) begin
            ack0_d  = ~owner_o;
            ack1_d  = owner_o;
            state_d = IDLE;
        end
        if (abort) begin
            err_d       = 1'b1;
            pix_write_d = 1'b0;
            cuvz_ack_d  = 1'b0;
        end
        if (done) begin
            if (owner_o) cnt1_d = cnt1_o + cnt_width'(1);
            else         cnt0_d = cnt0_o + cnt_width'(1);
        end
        if (clr_i) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_gfx256_cuvz_arb.sv
// Directed self-checking bench for gfx256_cuvz_arb with small interpolator and pixel-stage models.
module tb_gfx256_cuvz_arb;

    localparam int unsigned pw = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req0_i, req1_i, clr_i;
    logic [pw-1:0] x0_i, y0_i, f00_i, f01_i, x1_i, y1_i, f10_i, f11_i;
    logic          ack0_o, ack1_o, cuvz_write_o, cuvz_ack_o, pix_write_o;
    logic [pw-1:0] cuvz_x_o, cuvz_y_o, cuvz_f0_o, cuvz_f1_o;
    logic          cuvz_write_i, cuvz_ack_i, pix_ack_i;
    logic          owner_o, busy_o, err_o;
    logic [31:0]   cnt0_o, cnt1_o;

    int errors = 0;
    int checks = 0;
    bit ic_en;
    int ic_cnt;
    bit ic_pend;
    int px_stall;
    int px_wait;
    int grant_q[$];

    always #5 clk_i = ~clk_i;

    gfx256_cuvz_arb #(.point_width(pw), .timeout(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .x0_i(x0_i), .y0_i(y0_i), .f00_i(f00_i), .f01_i(f01_i), .ack0_o(ack0_o),
        .req1_i(req1_i), .x1_i(x1_i), .y1_i(y1_i), .f10_i(f10_i), .f11_i(f11_i), .ack1_o(ack1_o),
        .cuvz_write_o(cuvz_write_o), .cuvz_x_o(cuvz_x_o), .cuvz_y_o(cuvz_y_o),
        .cuvz_f0_o(cuvz_f0_o), .cuvz_f1_o(cuvz_f1_o),
        .cuvz_write_i(cuvz_write_i), .cuvz_ack_o(cuvz_ack_o), .cuvz_ack_i(cuvz_ack_i),
        .pix_write_o(pix_write_o), .pix_ack_i(pix_ack_i),
        .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o), .clr_i(clr_i),
        .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return cuvz_write_o;
            1:       return pix_write_o;
            2:       return cuvz_ack_o;
            3:       return ack0_o;
            4:       return ack1_o;
            5:       return err_o;
            6:       return ack0_o | ack1_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int budget, input string tag, output int lat);
        lat = 0;
        while (!sig(sel) && lat < budget) begin
            cyc();
            lat++;
        end
        if (!sig(sel)) check({tag, "_wait"}, 32'(sig(sel)), 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Interpolator: result valid 3 cycles after the start strobe, done pulse after its ack
    initial begin
        cuvz_write_i = 1'b0;
        cuvz_ack_i   = 1'b0;
        ic_cnt       = 0;
        ic_pend      = 1'b0;
        forever begin
            @(negedge clk_i);
            cuvz_ack_i = 1'b0;
            if (rst_i) begin
                cuvz_write_i = 1'b0;
                ic_cnt       = 0;
                ic_pend      = 1'b0;
            end else if (cuvz_write_o && ic_en) begin
                ic_cnt = 3;
            end else if (ic_cnt != 0) begin
                ic_cnt--;
                if (ic_cnt == 0) cuvz_write_i = 1'b1;
            end else if (cuvz_write_i && cuvz_ack_o) begin
                cuvz_write_i = 1'b0;
                ic_pend      = 1'b1;
            end else if (ic_pend) begin
                cuvz_ack_i = 1'b1;
                ic_pend    = 1'b0;
            end
        end
    end

    // Downstream pixel stage: accepts after px_stall cycles of pix_write_o
    initial begin
        pix_ack_i = 1'b0;
        px_wait   = 0;
        forever begin
            @(negedge clk_i);
            if (pix_write_o && !rst_i) begin
                if (px_wait == px_stall) begin
                    pix_ack_i = 1'b1;
                    px_wait   = 0;
                end else begin
                    pix_ack_i = 1'b0;
                    px_wait++;
                end
            end else begin
                pix_ack_i = 1'b0;
                px_wait   = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (cuvz_write_o) grant_q.push_back(int'(owner_o));
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: run did not finish, errors=%0d", errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        int bad;
        logic [31:0] gv;
        rst_i = 1'b1; clr_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0;
        x0_i = '0; y0_i = '0; f00_i = '0; f01_i = '0;
        x1_i = '0; y1_i = '0; f10_i = '0; f11_i = '0;
        ic_en = 1'b1; px_stall = 0;
        repeat (3) cyc();
        rst_i = 1'b0;
        cyc();
        check("rst_flags", 32'({cuvz_write_o, cuvz_ack_o, pix_write_o, ack0_o, ack1_o, busy_o, err_o, owner_o}), 32'd0);
        check("rst_cnt", cnt0_o | cnt1_o, 32'd0);
        check("rst_ops", {cuvz_x_o, cuvz_f1_o}, 32'd0);

        // Single port-0 transaction
        x0_i = 16'd10; y0_i = 16'd20; f00_i = 16'h4000; f01_i = 16'h4000; req0_i = 1'b1;
        wait_until(0, 10, "t1_issue", lat);
        check("t1_issue_lat", 32'(lat), 32'd1);
        check("t1_xy", {cuvz_x_o, cuvz_y_o}, {16'd10, 16'd20});
        check("t1_f", {cuvz_f0_o, cuvz_f1_o}, 32'h4000_4000);
        check("t1_owner_busy", 32'({owner_o, busy_o}), 32'b01);
        cyc();
        check("t1_write_pulse", 32'(cuvz_write_o), 32'd0);
        wait_until(1, 10, "t1_pix", lat);
        check("t1_pix_lat", 32'(lat), 32'd3);
        check("t1_no_early_ack", 32'(cuvz_ack_o), 32'd0);
        wait_until(2, 10, "t1_cack", lat);
        check("t1_cack_lat", 32'(lat), 32'd1);
        check("t1_pix_drop", 32'(pix_write_o), 32'd0);
        wait_until(3, 10, "t1_ack0", lat);
        check("t1_ack0_lat", 32'(lat), 32'd2);
        check("t1_cnt0", cnt0_o, 32'd1);
        check("t1_idle", 32'({busy_o, owner_o, ack1_o}), 32'd0);
        cyc();
        req0_i = 1'b0;
        check("t1_no_regrant", 32'({busy_o, cuvz_write_o, ack0_o}), 32'd0);

        // Both ports held: strict alternation starting at port 0
        do_reset();
        grant_q.delete();
        x0_i = 16'h0A0A; x1_i = 16'h0B0B; req0_i = 1'b1; req1_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_until(6, 30, "t2_ack", lat);
            check("t2_ack_port", 32'(ack1_o), 32'(i % 2));
            if (i == 3) begin
                req0_i = 1'b0;
                req1_i = 1'b0;
            end
            cyc();
        end
        check("t2_cnt0", cnt0_o, 32'd2);
        check("t2_cnt1", cnt1_o, 32'd2);
        gv = '0;
        foreach (grant_q[k]) gv = (gv << 4) | 32'(grant_q[k]);
        check("t2_grant_num", 32'(grant_q.size()), 32'd4);
        check("t2_grant_order", gv, 32'h0000_0101);
        check("t2_idle", 32'(busy_o), 32'd0);

        // Downstream stall of 1000 cycles
        px_stall = 1000; req0_i = 1'b1;
        wait_until(1, 20, "t3_pix", lat);
        bad = 0;
        repeat (1000) begin
            cyc();
            if (!pix_write_o || err_o || cuvz_ack_o) bad++;
        end
        check("t3_stall_hold", 32'(bad), 32'd0);
        wait_until(2, 5, "t3_cack", lat);
        check("t3_cack_lat", 32'(lat), 32'd1);
        wait_until(3, 10, "t3_ack0", lat);
        check("t3_cnt0", cnt0_o, 32'd3);
        check("t3_err", 32'(err_o), 32'd0);
        cyc();
        req0_i = 1'b0; px_stall = 0;

        // Interpolator silent: watchdog abort on port 1
        ic_en = 1'b0; req1_i = 1'b1;
        wait_until(0, 10, "t4_issue", lat);
        check("t4_owner", 32'(owner_o), 32'd1);
        wait_until(5, 20, "t4_err", lat);
        check("t4_err_lat", 32'(lat), 32'd9);
        check("t4_abort_flags", 32'({ack1_o, ack0_o, pix_write_o, cuvz_ack_o, busy_o}), 32'b10000);
        check("t4_cnt1", cnt1_o, 32'd2);
        cyc();
        req1_i = 1'b0;
        check("t4_sticky", 32'({err_o, ack1_o, busy_o}), 32'b100);
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        check("t4_clr_err", 32'(err_o), 32'd0);
        check("t4_clr_cnt", cnt0_o | cnt1_o, 32'd0);
        ic_en = 1'b1;

        // Operands frozen while calculating
        x0_i = 16'h1111; y0_i = 16'h2222; f00_i = 16'd1; f01_i = 16'd2; req0_i = 1'b1;
        wait_until(0, 10, "t5_issue", lat);
        cyc();
        x0_i = 16'hAAAA; y0_i = 16'hBBBB;
        cyc();
        cyc();
        check("t5_frozen_xy", {cuvz_x_o, cuvz_y_o}, 32'h1111_2222);
        wait_until(3, 20, "t5_ack0", lat);
        check("t5_cnt0", cnt0_o, 32'd1);
        cyc();
        req0_i = 1'b0;

        // Reset while in OUT, then a normal port-1 transaction
        px_stall = 50; x1_i = 16'h0C0C; req1_i = 1'b1;
        wait_until(1, 20, "t6_pix", lat);
        cyc();
        rst_i = 1'b1;
        cyc();
        check("t6_rst_flags", 32'({pix_write_o, busy_o, ack0_o, ack1_o, cuvz_ack_o, err_o}), 32'd0);
        check("t6_rst_cnt", cnt0_o | cnt1_o, 32'd0);
        cyc();
        check("t6_rst_noack", 32'({ack0_o, ack1_o, busy_o}), 32'd0);
        rst_i = 1'b0; px_stall = 0;
        wait_until(0, 10, "t6_issue", lat);
        check("t6_issue_lat", 32'(lat), 32'd1);
        check("t6_owner_x", {15'd0, owner_o, cuvz_x_o}, 32'h0001_0C0C);
        wait_until(4, 20, "t6_ack1", lat);
        check("t6_cnt", {cnt1_o[15:0], cnt0_o[15:0]}, 32'h0001_0000);
        cyc();
        req1_i = 1'b0;
        cyc();
        check("t6_idle", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gfx256_cuvz_arb.md
Name: gfx256_cuvz_arb

Overview:
Two-port round-robin arbiter and sequencer for the single interpolation (colour/UV/Z) unit. It accepts pixel requests (x, y, two barycentric factors) from two rasterizer sources, latches the winner's operands and issues them to the interpolator. It waits for the interpolator's write strobe, forwards it to the downstream pixel stage, then completes the interpolator ack round-trip and acknowledges the winning requester. A watchdog and per-port pixel counters support debug.

Parameters:
point_width, 16, width of x, y and factor buses
timeout, 255, watchdog cycles allowed in CALC or RELEASE before abort (8-bit counter, 1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req0_i  in  1  port 0 request; held until ack0_o
x0_i, y0_i, f00_i, f01_i  in  point_width each  port 0 pixel position, factor0, factor1
ack0_o  out  1  one-cycle completion pulse to port 0
req1_i  in  1  port 1 request
x1_i, y1_i, f10_i, f11_i  in  point_width each  port 1 operands
ack1_o  out  1  one-cycle completion pulse to port 1
cuvz_write_o  out  1  one-cycle start strobe to interpolator
cuvz_x_o, cuvz_y_o, cuvz_f0_o, cuvz_f1_o  out  point_width each  latched operands to interpolator
cuvz_write_i  in  1  interpolator result-valid (level, held until its ack)
cuvz_ack_o  out  1  one-cycle ack to interpolator
cuvz_ack_i  in  1  interpolator done pulse
pix_write_o  out  1  result valid to downstream pixel stage
pix_ack_i  in  1  downstream accept
owner_o  out  1  index of port currently owning the interpolator
busy_o  out  1  high in any state other than IDLE
err_o  out  1  sticky watchdog error
clr_i  in  1  clears err_o and both counters
cnt0_o, cnt1_o  out  32 each  completed-pixel counts per port

Behaviour:
- Reset: state IDLE; all strobes, busy_o, err_o, owner_o and cnt* are 0; operand outputs are 0; last_grant=1 (port 0 wins first tie).
- States: IDLE, ISSUE, CALC, OUT, RELEASE. All outputs are registered.
- IDLE: if exactly one reqN_i is high, grant N. If both are high, grant !last_grant. On grant: latch that port's x, y, f0, f1 into cuvz_*_o; owner_o<=N; last_grant<=N; go to ISSUE. Operands are frozen until the next grant.
- ISSUE: cuvz_write_o=1 for exactly this one cycle; go to CALC. Load the watchdog with timeout.
- CALC: wait for cuvz_write_i=1, then pix_write_o<=1 and go to OUT. The watchdog decrements each cycle.
- OUT: pix_write_o stays high until pix_ack_i=1. pix_ack_i is ignored when pix_write_o=0. On accept: pix_write_o<=0, cuvz_ack_o<=1 for one cycle; reload the watchdog; go to RELEASE. OUT has no timeout; downstream may stall indefinitely.
- RELEASE: wait for cuvz_ack_i=1, then ackN_o<=1 for one cycle, cntN<=cntN+1 (wraps at 2^32), go to IDLE.
- Minimum occupancy is 1 (IDLE) + 1 (ISSUE) + CALC + OUT + RELEASE cycles. Back-to-back grants are allowed: a request sampled in the cycle the ack pulse is driven (the IDLE cycle) is granted.
- Because ackN_o rises in the IDLE cycle, a requester still holding reqN_i in that cycle is not re-granted. The granted request is masked for the cycle its ack is high.
- Watchdog: if it reaches 0 in CALC or RELEASE, set err_o=1 and go to IDLE. On abort:
  - pulse ackN_o;
  - do not increment the counter;
  - force pix_write_o=0 and cuvz_ack_o=0.
- clr_i: clears err_o, cnt0_o and cnt1_o next cycle. If clr_i and a counter increment coincide, clr_i wins (count=0).
- Reset mid-operation returns to IDLE immediately. No pending ack is issued.
- Requests arriving while busy are held by the requester. No queueing inside the block.

Test Plan:
- Single req0 with x=10, y=20, f0=0x4000, f1=0x4000; interpolator model answers in 3 cycles; pix_ack_i immediate -> cuvz_write_o one pulse with those operands; pix_write_o then cuvz_ack_o then ack0_o; cnt0_o=1, owner_o=0.
- req0 and req1 both held continuously for 4 transactions -> grant order 0,1,0,1; cnt0_o=2, cnt1_o=2; never two consecutive grants to one port.
- Downstream stalls pix_ack_i for 1000 cycles -> pix_write_o held high throughout, err_o stays 0, and cuvz_ack_o is not issued until the accept.
- Interpolator never raises cuvz_write_i with timeout=8 -> err_o=1 after 8 CALC cycles; ack1_o pulses; cnt1_o unchanged; clr_i then clears err_o.
- Change x0_i/y0_i during CALC -> cuvz_x_o/cuvz_y_o remain the latched values.
- Assert rst_i while in OUT -> next cycle pix_write_o=0, busy_o=0, counters=0, no ack pulse; a subsequent req1 is served normally.
